// File: rtl/menu_overlay_nav_pkg.sv
// Shared definitions for the menu overlay: character codes, glyph cell size, fixed text tuples.
// Pure constants/functions, no latency.
// Not applicable (no handshake).
package menu_overlay_nav_pkg;

  // Character codes understood by the glyph generator (A=0..Z=25, digits 26..35)
  localparam logic [5:0] CH_A = 6'd0,  CH_C = 6'd2,  CH_D = 6'd3,  CH_E = 6'd4;
  localparam logic [5:0] CH_F = 6'd5,  CH_G = 6'd6,  CH_H = 6'd7,  CH_I = 6'd8;
  localparam logic [5:0] CH_K = 6'd10, CH_L = 6'd11, CH_M = 6'd12, CH_N = 6'd13;
  localparam logic [5:0] CH_O = 6'd14, CH_R = 6'd17, CH_S = 6'd18, CH_T = 6'd19;
  localparam logic [5:0] CH_U = 6'd20, CH_V = 6'd21, CH_W = 6'd22, CH_X = 6'd23;
  localparam logic [5:0] CH_0 = 6'd26, CH_COLON = 6'd36, CH_SPACE = 6'd37;

  // Default geometry
  localparam int ROW_PITCH_DEF  = 24;
  localparam int CHAR_PITCH_DEF = 15;
  localparam int LABEL_DX       = 55;   // labels start this far right of the ON/OFF text
  localparam int CURSOR_DX      = 20;   // cursor marker sits this far left of the ON/OFF text
  localparam int CLOCK_Y        = 960;  // y of the HH:MM row

  // Character slots along a scanline: 0..3 text columns, 4..7 label, 8..12 clock
  localparam int SLOT_LABEL0 = 4;
  localparam int SLOT_CLOCK0 = 8;
  localparam int N_SLOTS     = 13;

  // Four-char tuples, char 0 in the LSBs
  localparam logic [23:0] ON_CODES    = {CH_SPACE, CH_SPACE, CH_N, CH_O};
  localparam logic [23:0] OFF_CODES   = {CH_SPACE, CH_F, CH_F, CH_O};
  localparam logic [23:0] TITLE_CODES = {CH_U, CH_N, CH_E, CH_M};

  // Labels for up to 8 rows, row 0 in the LSBs: AXIS GRID TICK WAVE CURS TRIG SCAL HOLD
  localparam logic [191:0] DEFAULT_LABELS = {
    {CH_D, CH_L, CH_O, CH_H}, {CH_L, CH_A, CH_C, CH_S},
    {CH_G, CH_I, CH_R, CH_T}, {CH_S, CH_R, CH_U, CH_C},
    {CH_E, CH_V, CH_A, CH_W}, {CH_K, CH_C, CH_I, CH_T},
    {CH_D, CH_I, CH_R, CH_G}, {CH_S, CH_I, CH_X, CH_A}};

  // Which vertical band of the menu the current scanline falls in
  typedef enum logic [1:0] {BAND_NONE, BAND_TITLE, BAND_ROW, BAND_CLOCK} band_e;

  function automatic logic [5:0] pick6(input logic [23:0] v, input logic [1:0] i);
    return v[int'(i)*6 +: 6];
  endfunction

endpackage

// File: rtl/menu_overlay_nav_glyph.sv
// Glyph generator: 8x8 cell, lit pixels are a code-dependent diagonal stripe pattern.
// Combinational, zero latency.
// No handshake.
module menu_overlay_nav_glyph
  import menu_overlay_nav_pkg::*;
(
  input  logic       i_en,
  input  logic [5:0] i_code,
  input  logic [2:0] i_gx,
  input  logic [2:0] i_gy,
  output logic       o_hit
);

  logic [7:0] w_pat;
  logic [2:0] w_idx;

  // Pattern byte is the code with two always-on bits; the diagonal index walks it
  assign w_pat = {i_code, 2'b11};
  assign w_idx = i_gx + i_gy;
  assign o_hit = i_en && (i_code != CH_SPACE) && w_pat[w_idx];

endmodule

// File: rtl/menu_overlay_nav.sv
// Interactive menu overlay: cursor/toggle control plus a 2-stage pixel flag pipeline.
// Pixel flags appear 2 CLK_VGA cycles after the coordinates; control updates next cycle.
// No backpressure: one pixel per clock, button pulses consumed when Menu_Sw=1.
module menu_overlay_nav
  import menu_overlay_nav_pkg::*;
#(
  parameter int                     N_ITEMS    = 5,
  parameter logic [N_ITEMS-1:0]     ITEM_RESET = N_ITEMS'(5'b01111),
  parameter logic [N_ITEMS*24-1:0]  LABELS     = DEFAULT_LABELS[N_ITEMS*24-1:0],
  parameter int                     MENU_X0    = 1040,
  parameter int                     MENU_Y0    = 640,
  parameter int                     TEXT_X0    = 1105,
  parameter int                     ROW_Y0     = 688,
  parameter int                     ROW_PITCH  = ROW_PITCH_DEF,
  parameter int                     CHAR_PITCH = CHAR_PITCH_DEF
) (
  input  logic               CLK_VGA,
  input  logic               RESET,
  input  logic [11:0]        VGA_HORZ_COORD,
  input  logic [11:0]        VGA_VERT_COORD,
  input  logic               Menu_Sw,
  input  logic               Btn_Up,
  input  logic               Btn_Down,
  input  logic               Btn_Sel,
  input  logic [23:0]        Clock_Time,
  output logic [N_ITEMS-1:0] Item_On,
  output logic [2:0]         Cursor_Idx,
  output logic               Menu_Box,
  output logic               Menu_Border,
  output logic               Menu_Text,
  output logic               Menu_Cursor
);

  localparam logic [11:0] L_MENU_X0 = 12'(MENU_X0);
  localparam logic [11:0] L_MENU_Y0 = 12'(MENU_Y0);
  localparam logic [11:0] L_CLOCK_Y = 12'(CLOCK_Y);
  localparam logic [11:0] L_CUR_X0  = 12'(TEXT_X0 - CURSOR_DX);
  localparam logic [2:0]  L_LAST    = 3'(N_ITEMS - 1);

  function automatic logic [11:0] row_y0(input int k);
    return 12'(ROW_Y0 + k * ROW_PITCH);
  endfunction

  function automatic logic [11:0] slot_x0(input int s);
    if (s < SLOT_LABEL0)      return 12'(TEXT_X0 + s * CHAR_PITCH);
    else if (s < SLOT_CLOCK0) return 12'(TEXT_X0 + LABEL_DX + (s - SLOT_LABEL0) * CHAR_PITCH);
    else                      return 12'(MENU_X0 + (s - SLOT_CLOCK0) * CHAR_PITCH);
  endfunction

  logic [N_ITEMS-1:0] r_item_on;
  logic [2:0]         r_cursor;

  // Control: cursor move with wrap, Sel toggles the row under the cursor before any move
  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      r_item_on <= ITEM_RESET;
      r_cursor  <= '0;
    end else if (Menu_Sw) begin
      if (Btn_Sel)
        r_item_on <= r_item_on ^ (N_ITEMS'(1) << r_cursor);
      if (Btn_Up && !Btn_Down)
        r_cursor <= (r_cursor == 3'd0) ? L_LAST : r_cursor - 3'd1;
      else if (Btn_Down && !Btn_Up)
        r_cursor <= (r_cursor == L_LAST) ? 3'd0 : r_cursor + 3'd1;
    end
  end

  assign Item_On    = r_item_on;
  assign Cursor_Idx = r_cursor;

  // ---------------- S1: band/row and slot decode by compare chains ----------------
  band_e      w_band;
  logic [2:0] w_row, w_gy, w_gx;
  logic [3:0] w_slot;
  logic       w_slot_vld, w_box, w_border;

  assign w_box    = (VGA_HORZ_COORD >= L_MENU_X0) && (VGA_VERT_COORD >= L_MENU_Y0);
  assign w_border = w_box && ((VGA_HORZ_COORD <= L_MENU_X0 + 12'd2) ||
                              (VGA_VERT_COORD <= L_MENU_Y0 + 12'd2));

  // Vertical band and row index, then the character slot valid for that band
  always_comb begin
    w_band = BAND_NONE;
    w_row  = '0;
    w_gy   = '0;
    if (VGA_VERT_COORD >= L_MENU_Y0 && VGA_VERT_COORD < L_MENU_Y0 + 12'd8) begin
      w_band = BAND_TITLE;
      w_gy   = 3'(VGA_VERT_COORD - L_MENU_Y0);
    end
    if (VGA_VERT_COORD >= L_CLOCK_Y && VGA_VERT_COORD < L_CLOCK_Y + 12'd8) begin
      w_band = BAND_CLOCK;
      w_gy   = 3'(VGA_VERT_COORD - L_CLOCK_Y);
    end
    for (int k = 0; k < N_ITEMS; k++) begin
      if (VGA_VERT_COORD >= row_y0(k) && VGA_VERT_COORD < row_y0(k) + 12'd8) begin
        w_band = BAND_ROW;
        w_row  = 3'(k);
        w_gy   = 3'(VGA_VERT_COORD - row_y0(k));
      end
    end
    w_slot     = '0;
    w_slot_vld = 1'b0;
    w_gx       = '0;
    // Clock slots overlap the text columns in x, so only the band's own slots are decoded
    for (int s = 0; s < N_SLOTS; s++) begin
      if (((s >= SLOT_CLOCK0) == (w_band == BAND_CLOCK)) &&
          VGA_HORZ_COORD >= slot_x0(s) && VGA_HORZ_COORD < slot_x0(s) + 12'd8) begin
        w_slot     = 4'(s);
        w_slot_vld = 1'b1;
        w_gx       = 3'(VGA_HORZ_COORD - slot_x0(s));
      end
    end
  end

  logic [11:0] r_s1_x, r_s1_y;
  band_e       r_s1_band;
  logic [2:0]  r_s1_row, r_s1_gx, r_s1_gy;
  logic [3:0]  r_s1_slot;
  logic        r_s1_slot_vld, r_s1_box, r_s1_border, r_s1_sw;

  // S1 register stage
  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      r_s1_x <= '0; r_s1_y <= '0; r_s1_band <= BAND_NONE; r_s1_row <= '0;
      r_s1_gx <= '0; r_s1_gy <= '0; r_s1_slot <= '0; r_s1_slot_vld <= 1'b0;
      r_s1_box <= 1'b0; r_s1_border <= 1'b0; r_s1_sw <= 1'b0;
    end else begin
      r_s1_x <= VGA_HORZ_COORD; r_s1_y <= VGA_VERT_COORD; r_s1_band <= w_band;
      r_s1_row <= w_row; r_s1_gx <= w_gx; r_s1_gy <= w_gy; r_s1_slot <= w_slot;
      r_s1_slot_vld <= w_slot_vld; r_s1_box <= w_box; r_s1_border <= w_border;
      r_s1_sw <= Menu_Sw;
    end
  end

  // ---------------- S2: character select, glyph hit, cursor ----------------
  logic [5:0]  w_code;
  logic        w_en, w_on, w_hit, w_cur_hit;
  logic [23:0] w_label;
  logic [11:0] w_cur_y0;

  assign w_on     = |(r_item_on & (N_ITEMS'(1) << r_s1_row));
  assign w_cur_y0 = 12'(ROW_Y0 + int'(r_cursor) * ROW_PITCH + 4);
  assign w_cur_hit = (r_s1_x >= L_CUR_X0) && (r_s1_x < L_CUR_X0 + 12'd8) &&
                     (r_s1_y >= w_cur_y0) && (r_s1_y < w_cur_y0 + 12'd8);

  // Pick the character under the pixel from live toggle state, labels or clock input
  always_comb begin
    w_label = '0;
    for (int k = 0; k < N_ITEMS; k++)
      if (r_s1_row == 3'(k)) w_label = LABELS[k*24 +: 24];
    w_code = CH_SPACE;
    w_en   = 1'b0;
    if (r_s1_slot_vld) begin
      case (r_s1_band)
        BAND_TITLE: if (r_s1_slot < 4'd4) begin
          w_code = pick6(TITLE_CODES, 2'(r_s1_slot));
          w_en   = 1'b1;
        end
        BAND_ROW: if (r_s1_slot < 4'd3) begin
          w_code = pick6(w_on ? ON_CODES : OFF_CODES, 2'(r_s1_slot));
          w_en   = 1'b1;
        end else if (r_s1_slot >= 4'd4 && r_s1_slot < 4'd8) begin
          w_code = pick6(w_label, 2'(r_s1_slot - 4'd4));
          w_en   = 1'b1;
        end
        BAND_CLOCK: begin
          w_en = 1'b1;
          case (r_s1_slot)
            4'd8:    w_code = Clock_Time[23:18];
            4'd9:    w_code = Clock_Time[17:12];
            4'd10:   w_code = CH_COLON;
            4'd11:   w_code = Clock_Time[11:6];
            default: w_code = Clock_Time[5:0];
          endcase
        end
        default: w_en = 1'b0;
      endcase
    end
  end

  menu_overlay_nav_glyph u_glyph (
    .i_en   (w_en),
    .i_code (w_code),
    .i_gx   (r_s1_gx),
    .i_gy   (r_s1_gy),
    .o_hit  (w_hit)
  );

  // S2 register stage: flags gated by the Menu_Sw that travelled with the pixel
  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      Menu_Box <= 1'b0; Menu_Border <= 1'b0; Menu_Text <= 1'b0; Menu_Cursor <= 1'b0;
    end else begin
      Menu_Box    <= r_s1_sw & r_s1_box;
      Menu_Border <= r_s1_sw & r_s1_border;
      Menu_Text   <= r_s1_sw & w_hit;
      Menu_Cursor <= r_s1_sw & w_cur_hit;
    end
  end

endmodule

// File: tb/tb_menu_overlay_nav.sv
// Bench for menu_overlay_nav: three instances (N_ITEMS 5, 3, 8) on shared stimulus,
// checked every cycle against a placement-list reference model plus literal pins.
module tb_menu_overlay_nav;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sw, up, dn, sel;
  logic [11:0] hx, vy;
  logic [23:0] ctime;

  logic [4:0] item5;
  logic [2:0] item3;
  logic [7:0] item8;
  logic [2:0] cur5, cur3, cur8;
  logic [2:0] f_box, f_bord, f_txt, f_cur;

  menu_overlay_nav u5 (
    .CLK_VGA(clk), .RESET(rst), .VGA_HORZ_COORD(hx), .VGA_VERT_COORD(vy),
    .Menu_Sw(sw), .Btn_Up(up), .Btn_Down(dn), .Btn_Sel(sel), .Clock_Time(ctime),
    .Item_On(item5), .Cursor_Idx(cur5), .Menu_Box(f_box[0]), .Menu_Border(f_bord[0]),
    .Menu_Text(f_txt[0]), .Menu_Cursor(f_cur[0]));

  menu_overlay_nav #(.N_ITEMS(3), .ITEM_RESET(3'b101)) u3 (
    .CLK_VGA(clk), .RESET(rst), .VGA_HORZ_COORD(hx), .VGA_VERT_COORD(vy),
    .Menu_Sw(sw), .Btn_Up(up), .Btn_Down(dn), .Btn_Sel(sel), .Clock_Time(ctime),
    .Item_On(item3), .Cursor_Idx(cur3), .Menu_Box(f_box[1]), .Menu_Border(f_bord[1]),
    .Menu_Text(f_txt[1]), .Menu_Cursor(f_cur[1]));

  menu_overlay_nav #(.N_ITEMS(8), .ITEM_RESET(8'hA5)) u8 (
    .CLK_VGA(clk), .RESET(rst), .VGA_HORZ_COORD(hx), .VGA_VERT_COORD(vy),
    .Menu_Sw(sw), .Btn_Up(up), .Btn_Down(dn), .Btn_Sel(sel), .Clock_Time(ctime),
    .Item_On(item8), .Cursor_Idx(cur8), .Menu_Box(f_box[2]), .Menu_Border(f_bord[2]),
    .Menu_Text(f_txt[2]), .Menu_Cursor(f_cur[2]));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         NU[3]       = '{5, 3, 8};
  logic [7:0] RST_ITEM[3] = '{8'h0F, 8'h05, 8'hA5};
  string      LBL[8]      = '{"AXIS", "GRID", "TICK", "WAVE", "CURS", "TRIG", "SCAL", "HOLD"};
  logic [7:0] m_item[3];
  int         m_cur[3];
  logic [3:0] exp_f[3];          // {box, border, text, cursor}
  int         d1_x = 0, d1_y = 0;
  bit         d1_sw = 1'b0;

  function automatic int code_of(input byte c);
    if (c == 8'd32) return 37;                    // space
    if (c == 8'd58) return 36;                    // colon
    if (c >= 8'd48 && c <= 8'd57) return 26 + int'(c) - 48;
    return int'(c) - 65;                          // 'A'..'Z'
  endfunction

  // Font: code 37 blank, otherwise pixel (gx,gy) lit iff bit ((gx+gy) mod 8) of 4*code+3
  function automatic bit font(input int code, input int gx, input int gy);
    if (code == 37) return 1'b0;
    return bit'(((code * 4 + 3) >> ((gx + gy) % 8)) & 1);
  endfunction

  function automatic bit glyph_at(input int x, input int y, input int x0, input int y0, input int code);
    if (x >= x0 && x < x0 + 8 && y >= y0 && y < y0 + 8) return font(code, x - x0, y - y0);
    return 1'b0;
  endfunction

  function automatic bit text_model(input int n, input logic [7:0] item, input int x, input int y,
                                    input logic [23:0] t);
    bit    hit;
    string s;
    string title;
    int    cx[5];
    int    cc[5];
    hit   = 1'b0;
    title = "MENU";
    for (int i = 0; i < 4; i++) hit |= glyph_at(x, y, 1105 + 15 * i, 640, code_of(title[i]));
    for (int k = 0; k < n; k++) begin
      s = item[k] ? "ON " : "OFF";
      for (int i = 0; i < 3; i++) hit |= glyph_at(x, y, 1105 + 15 * i, 688 + 24 * k, code_of(s[i]));
      s = LBL[k];
      for (int j = 0; j < 4; j++) hit |= glyph_at(x, y, 1160 + 15 * j, 688 + 24 * k, code_of(s[j]));
    end
    cx = '{1040, 1055, 1070, 1085, 1100};
    cc = '{int'(t[23:18]), int'(t[17:12]), 36, int'(t[11:6]), int'(t[5:0])};
    for (int i = 0; i < 5; i++) hit |= glyph_at(x, y, cx[i], 960, cc[i]);
    return hit;
  endfunction

  // At each edge: flags for the pixel applied one edge earlier, using pre-edge state
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (rst) begin
        exp_f[u]  = 4'b0;
        m_item[u] = RST_ITEM[u];
        m_cur[u]  = 0;
      end else begin
        if (d1_sw) begin
          exp_f[u][3] = (d1_x >= 1040) && (d1_y >= 640);
          exp_f[u][2] = exp_f[u][3] && (d1_x <= 1042 || d1_y <= 642);
          exp_f[u][1] = text_model(NU[u], m_item[u], d1_x, d1_y, ctime);
          exp_f[u][0] = (d1_x >= 1085 && d1_x <= 1092 &&
                         d1_y >= 692 + 24 * m_cur[u] && d1_y <= 699 + 24 * m_cur[u]);
        end else begin
          exp_f[u] = 4'b0;
        end
        if (sw) begin
          if (sel) m_item[u] = m_item[u] ^ (8'd1 << m_cur[u]);
          if (up && !dn) m_cur[u] = (m_cur[u] + NU[u] - 1) % NU[u];
          if (dn && !up) m_cur[u] = (m_cur[u] + 1) % NU[u];
        end
      end
    end
    if (rst) begin
      d1_x = 0; d1_y = 0; d1_sw = 1'b0;
    end else begin
      d1_x = int'(hx); d1_y = int'(vy); d1_sw = sw;
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    logic [7:0] it[3];
    int         cu[3];
    logic [3:0] fl[3];
    if (chk_en) begin
      it = '{{3'b0, item5}, {5'b0, item3}, item8};
      cu = '{int'(cur5), int'(cur3), int'(cur8)};
      for (int u = 0; u < 3; u++) begin
        fl[u] = {f_box[u], f_bord[u], f_txt[u], f_cur[u]};
        check($sformatf("N%0d Item_On", NU[u]), int'(it[u]), int'(m_item[u]));
        check($sformatf("N%0d Cursor_Idx", NU[u]), cu[u], m_cur[u]);
        check($sformatf("N%0d Menu_Box", NU[u]), int'(fl[u][3]), int'(exp_f[u][3]));
        check($sformatf("N%0d Menu_Border", NU[u]), int'(fl[u][2]), int'(exp_f[u][2]));
        check($sformatf("N%0d Menu_Text", NU[u]), int'(fl[u][1]), int'(exp_f[u][1]));
        check($sformatf("N%0d Menu_Cursor", NU[u]), int'(fl[u][0]), int'(exp_f[u][0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit u_, input bit d_, input bit s_);
    @(negedge clk);
    up = u_; dn = d_; sel = s_;
    @(negedge clk);
    up = 1'b0; dn = 1'b0; sel = 1'b0;
  endtask

  task automatic put_pix(input int x, input int y);
    @(negedge clk);
    hx = 12'(x); vy = 12'(y);
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic int pick_y();
    int k;
    if ($urandom % 4 != 0) begin
      k = int'($urandom % 10);
      if (k == 8) return 958 + int'($urandom % 12);
      if (k == 9) return 638 + int'($urandom % 12);
      return 686 + 24 * k + int'($urandom % 12);
    end
    return 630 + int'($urandom % 350);
  endfunction

  initial begin
    rst = 1'b1; sw = 1'b0; up = 1'b0; dn = 1'b0; sel = 1'b0;
    hx = 12'd1100; vy = 12'd700;
    ctime = {6'd27, 6'd28, 6'd29, 6'd26};          // "12:30"
    repeat (2) @(negedge clk);
    check("reset Item_On", int'(item5), 5'b01111);
    check("reset Cursor_Idx", int'(cur5), 0);
    check("reset flags", int'({f_box[0], f_bord[0], f_txt[0], f_cur[0]}), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    sw = 1'b1;
    pulse(1, 0, 0);                       check("up wraps 0->4", int'(cur5), 4);
    repeat (5) pulse(0, 1, 0);            check("down x5 back to 4", int'(cur5), 4);
    pulse(1, 1, 0);                       check("up+down holds", int'(cur5), 4);
    repeat (3) pulse(0, 1, 0);            check("cursor at 2", int'(cur5), 2);
    pulse(0, 0, 1);                       check("sel row 2", int'(item5), 5'b01011);
    pulse(0, 1, 1);
    check("sel+down toggles old row", int'(item5), 5'b01111);
    check("sel+down moves", int'(cur5), 3);

    sw = 1'b0;
    pulse(1, 0, 1);
    check("disabled Item_On held", int'(item5), 5'b01111);
    check("disabled Cursor held", int'(cur5), 3);
    @(negedge clk);                       check("disabled box off", int'(f_box[0]), 0);
    sw = 1'b1;
    repeat (2) @(negedge clk);            check("re-enabled box on", int'(f_box[0]), 1);

    put_pix(1040, 700);
    check("edge pixel border", int'(f_bord[0]), 1);
    check("edge pixel box", int'(f_box[0]), 1);
    put_pix(1039, 700);                   check("left of box", int'(f_box[0]), 0);
    put_pix(1105, 640);                   check("title M lit", int'(f_txt[0]), 1);
    put_pix(1107, 640);                   check("title M dark", int'(f_txt[0]), 0);
    put_pix(1160, 712);                   check("label G lit", int'(f_txt[0]), 1);
    put_pix(1162, 712);                   check("label G dark", int'(f_txt[0]), 0);
    put_pix(1044, 960);                   check("clock 1 dark", int'(f_txt[0]), 0);
    put_pix(1088, 766);                   check("cursor row 3", int'(f_cur[0]), 1);

    // Random pixels with random control activity
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      hx  = 12'(1020 + int'($urandom % 200));
      vy  = 12'(pick_y());
      up  = ($urandom % 12 == 0);
      dn  = ($urandom % 12 == 0);
      sel = ($urandom % 10 == 0);
      if ($urandom % 300 == 0) sw = ~sw;
      rst = ($urandom % 2000 == 0);
      if ($urandom % 700 == 0)
        ctime = {6'($urandom % 38), 6'($urandom % 38), 6'($urandom % 38), 6'($urandom % 38)};
    end

    // Scanline sweeps across the menu, one with a mid-line reset
    sw = 1'b1; rst = 1'b0;
    for (int l = 0; l < 32; l++) begin
      int y;
      y = pick_y();
      for (int x = 1025; x <= 1215; x++) begin
        @(negedge clk);
        hx  = 12'(x);
        vy  = 12'(y);
        rst = (l == 10 && x >= 1100 && x < 1103);
        up  = ($urandom % 64 == 0);
        dn  = ($urandom % 64 == 0);
        sel = ($urandom % 48 == 0);
      end
    end

    @(negedge clk);
    up = 1'b0; dn = 1'b0; sel = 1'b0; rst = 1'b0; sw = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
